// File: rtl/config_tx.sv
// Serial config frame transmitter: 16-bit header {length,type} then length payload words, MSB first on tdo/en.
// Latency: header bit 15 on tdo one cycle after start; pay_ready is a one-cycle request in each word's bit-0 cycle.
module config_tx #(
  parameter int GAP_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  cfg_type,
  input  logic [11:0] cfg_length,
  input  logic [15:0] pay_data,
  input  logic        pay_valid,
  output logic        pay_ready,
  output logic        tdo,
  output logic        en,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PAY  = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] sh_q, sh_d;
  logic [3:0]  bit_q, bit_d;
  logic [11:0] wcnt_q, wcnt_d;
  logic [7:0]  gap_q, gap_d;
  logic        tdo_q, tdo_d;
  logic        en_q, en_d;
  logic        busy_q, busy_d;
  logic        rdy_q, rdy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [15:0] hdr;
  logic        more_words;

  assign hdr = {cfg_length, cfg_type};

  // In HDR wcnt holds the full length; in PAY it counts words left including the one on the wire.
  assign more_words = (state_q == HDR) ? (wcnt_q != 12'd0) : (wcnt_q > 12'd1);

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    wcnt_d  = wcnt_q;
    gap_d   = gap_q;
    tdo_d   = tdo_q;
    en_d    = en_q;
    busy_d  = busy_q;
    rdy_d   = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = HDR;
          busy_d  = 1'b1;
          en_d    = 1'b1;
          tdo_d   = hdr[15];
          sh_d    = {hdr[14:0], 1'b0};
          bit_d   = 4'd15;
          wcnt_d  = cfg_length;
        end
      end
      HDR, PAY: begin
        if (bit_q != 4'd0) begin
          tdo_d = sh_q[15];
          sh_d  = {sh_q[14:0], 1'b0};
          bit_d = bit_q - 4'd1;
          rdy_d = (bit_q == 4'd1) && more_words;
        end else begin
          if (state_q == PAY) begin
            wcnt_d = wcnt_q - 12'd1;
          end
          if (more_words && pay_valid) begin
            state_d = PAY;
            tdo_d   = pay_data[15];
            sh_d    = {pay_data[14:0], 1'b0};
            bit_d   = 4'd15;
          end else begin
            // Either the last bit of the frame or an underrun: both close the frame here.
            state_d = GAP;
            en_d    = 1'b0;
            tdo_d   = 1'b0;
            sh_d    = 16'd0;
            gap_d   = GAP_LOAD;
            done_d  = !more_words;
            err_d   = more_words;
          end
        end
      end
      GAP: begin
        if (gap_q == 8'd0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_q    <= 16'd0;
      bit_q   <= 4'd0;
      wcnt_q  <= 12'd0;
      gap_q   <= 8'd0;
      tdo_q   <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      wcnt_q  <= wcnt_d;
      gap_q   <= gap_d;
      tdo_q   <= tdo_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      rdy_q   <= rdy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign pay_ready = rdy_q;
  assign tdo       = tdo_q;
  assign en        = en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

  a_done_err_excl: assert property (@(posedge clk) disable iff (!rst_n) !(done_q && err_q));
  a_tdo_quiet:     assert property (@(posedge clk) disable iff (!rst_n) !en_q |-> !tdo_q);
  a_en_in_busy:    assert property (@(posedge clk) disable iff (!rst_n) en_q |-> busy_q);

endmodule

// File: tb/tb_config_tx.sv
// Scoreboard bench for config_tx: stimulus queues expected frames, a monitor deserialises en/tdo and compares.
module tb_config_tx;
  localparam int GAP = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  cfg_type;
  logic [11:0] cfg_length;
  logic [15:0] pay_data;
  logic        pay_valid;
  logic        pay_ready;
  logic        tdo;
  logic        en;
  logic        busy;
  logic        done;
  logic        err;

  config_tx #(.GAP_CYCLES(GAP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cfg_type  (cfg_type),
    .cfg_length(cfg_length),
    .pay_data  (pay_data),
    .pay_valid (pay_valid),
    .pay_ready (pay_ready),
    .tdo       (tdo),
    .en        (en),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int          nbits;
    logic [63:0] bits;
    int          hs;
    bit          exp_done;
    bit          exp_err;
    bit          abort;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] pay_q[$];
  int          vectors = 0;
  int          miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic expect_frame(input int nbits, input logic [63:0] bits, input int hs,
                              input bit d, input bit e, input bit ab);
    exp_t x;
    x.nbits = nbits; x.bits = bits; x.hs = hs;
    x.exp_done = d; x.exp_err = e; x.abort = ab;
    exp_q.push_back(x);
  endtask

  task automatic send_frame(input logic [3:0] t, input logic [11:0] l);
    @(posedge clk); #2;
    start = 1'b1; cfg_type = t; cfg_length = l;
    @(posedge clk); #2;
    start = 1'b0; cfg_type = ~t; cfg_length = 12'hABC;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_timeout", 64'(ok), 64'd1);
  endtask

  // Payload source: presents the queue head, pops on a completed handshake.
  initial begin
    bit hs_now;
    pay_valid = 1'b0;
    pay_data  = 16'hDEAD;
    forever begin
      @(negedge clk);
      hs_now = pay_valid && pay_ready;
      @(posedge clk); #1;
      if (hs_now && pay_q.size() > 0) void'(pay_q.pop_front());
      pay_valid = (pay_q.size() > 0);
      pay_data  = (pay_q.size() > 0) ? pay_q[0] : 16'hDEAD;
    end
  end

  // Monitor: collects each contiguous en run and scores it against the next expected frame.
  logic [63:0] m_bits = 64'd0;
  int          m_n = 0;
  int          m_hs = 0;
  logic        prev_en = 1'b0;
  bit          in_gap = 1'b0;
  int          gap_seen = 0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      check("tdo_when_idle", 64'(tdo & ~en), 64'd0);
      check("done_err_excl", 64'(done & err), 64'd0);
      if (pay_valid && pay_ready) m_hs++;
      if (en) begin
        m_bits = {m_bits[62:0], tdo};
        m_n++;
      end else if (prev_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 64'(m_n), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("frame_abort", 64'(!rst_n), 64'(e.abort));
          if (e.abort) begin
            check("abort_pulses", 64'({done, err}), 64'd0);
          end else begin
            check("frame_len", 64'(m_n), 64'(e.nbits));
            check("frame_bits", m_bits, e.bits);
            check("handshakes", 64'(m_hs), 64'(e.hs));
            check("done", 64'(done), 64'(e.exp_done));
            check("err", 64'(err), 64'(e.exp_err));
            in_gap = 1'b1;
            gap_seen = 0;
          end
        end
        m_n = 0; m_bits = 64'd0; m_hs = 0;
      end else if (done || err) begin
        check("stray_pulse", 64'({done, err}), 64'd0);
      end
      if (in_gap) begin
        if (busy && !en && gap_seen < 300) begin
          gap_seen++;
        end else begin
          check("gap_cycles", 64'(gap_seen), 64'(GAP));
          in_gap = 1'b0;
        end
      end
      if (!rst_n) begin
        m_n = 0; m_bits = 64'd0; m_hs = 0; in_gap = 1'b0;
      end
      prev_en = en;
    end
  end

  // Loopback receiver: latches the header of each frame from en/tdi.
  logic [15:0] rx_sh = 16'd0;
  int          rx_n = 0;
  logic [3:0]  rx_type = 4'd0;
  logic [11:0] rx_len = 12'd0;

  initial forever begin
    @(negedge clk);
    if (!rst_n || !en) begin
      rx_n = 0;
    end else if (rx_n < 16) begin
      rx_sh = {rx_sh[14:0], tdo};
      rx_n++;
      if (rx_n == 16) begin
        rx_type = rx_sh[3:0];
        rx_len  = rx_sh[15:4];
      end
    end
  end

  initial begin
    #100000;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    bit seen_low;
    rst_n = 1'b0; start = 1'b0; cfg_type = 4'd0; cfg_length = 12'd0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({tdo, en, busy, pay_ready, done, err}), 64'd0);
    @(posedge clk); #2; rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_after_reset", 64'({en, busy}), 64'd0);

    // Header-only frame.
    expect_frame(16, 64'h0005, 0, 1'b1, 1'b0, 1'b0);
    send_frame(4'h5, 12'd0);
    wait_idle();

    // Two payload words, always valid.
    pay_q.push_back(16'hBEEF); pay_q.push_back(16'h1234);
    expect_frame(48, 64'h002A_BEEF_1234, 2, 1'b1, 1'b0, 1'b0);
    send_frame(4'hA, 12'd2);
    wait_idle();

    // Underrun on the second word request.
    pay_q.push_back(16'h5A5A);
    expect_frame(32, 64'h0021_5A5A, 1, 1'b0, 1'b1, 1'b0);
    send_frame(4'h1, 12'd2);
    wait_idle();

    // Starts during HDR and GAP must be dropped, not queued.
    pay_q.push_back(16'h0F0F);
    expect_frame(32, 64'h0017_0F0F, 1, 1'b1, 1'b0, 1'b0);
    send_frame(4'h7, 12'd1);
    repeat (4) @(posedge clk);
    #2; start = 1'b1; cfg_type = 4'hF; cfg_length = 12'd0;
    @(posedge clk); #2; start = 1'b0;
    seen_low = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!en) begin
        seen_low = 1'b1;
        break;
      end
    end
    check("en_fall_timeout", 64'(seen_low), 64'd1);
    @(posedge clk); #2; start = 1'b1; cfg_type = 4'hE; cfg_length = 12'd0;
    @(posedge clk); #2; start = 1'b0;
    wait_idle();
    expect_frame(16, 64'h0002, 0, 1'b1, 1'b0, 1'b0);
    send_frame(4'h2, 12'd0);
    wait_idle();

    // Reset while payload bit 7 is on the wire.
    pay_q.push_back(16'h1111); pay_q.push_back(16'h2222);
    expect_frame(0, 64'd0, 0, 1'b0, 1'b0, 1'b1);
    send_frame(4'h4, 12'd2);
    repeat (24) @(posedge clk);
    #2; rst_n = 1'b0;
    #1;
    check("reset_mid_frame", 64'({tdo, en, busy, pay_ready, done, err}), 64'd0);
    pay_q.delete();
    repeat (2) @(posedge clk);
    #2; rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("no_restart_after_reset", 64'({en, busy}), 64'd0);
    pay_q.push_back(16'hCAFE);
    expect_frame(32, 64'h0013_CAFE, 1, 1'b1, 1'b0, 1'b0);
    send_frame(4'h3, 12'd1);
    wait_idle();

    // Loopback into the header receiver.
    pay_q.push_back(16'h0F0F); pay_q.push_back(16'hA5A5); pay_q.push_back(16'hFFFF);
    expect_frame(64, 64'h0035_0F0F_A5A5_FFFF, 3, 1'b1, 1'b0, 1'b0);
    send_frame(4'h5, 12'd3);
    wait_idle();
    check("rx_type", 64'(rx_type), 64'h5);
    check("rx_len", 64'(rx_len), 64'h3);

    repeat (5) @(negedge clk);
    check("pending_frames", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
